// File: rtl/imm_extend_unit.sv
// Immediate extension unit: sign/zero/shift-by-one extension plus a prefix
// register that concatenates a latched upper immediate with the next one.
module imm_extend_unit #(
  parameter int IMM_W  = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  immed,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_immed,
  output logic              out_prefixed,
  output logic              prefix_pending
);

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_SHIFT1 = 2'b10;
  localparam logic [1:0] MODE_PREFIX = 2'b11;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] ext_immed_q, ext_immed_d;
  logic              out_prefixed_q, out_prefixed_d;
  logic              prefix_pending_q, prefix_pending_d;
  logic [IMM_W-1:0]  prefix_q, prefix_d;

  logic              accept;
  logic [DATA_W-1:0] sign_ext;
  logic [DATA_W-1:0] zero_ext;
  logic [DATA_W-1:0] shift_ext;
  logic [DATA_W-1:0] prefix_ext;

  // A slot opens whenever the output register is empty or being drained.
  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;

  assign sign_ext   = {{(DATA_W-IMM_W){immed[IMM_W-1]}}, immed};
  assign zero_ext   = {{(DATA_W-IMM_W){1'b0}}, immed};
  assign shift_ext  = {sign_ext[DATA_W-2:0], 1'b0};
  assign prefix_ext = DATA_W'({prefix_q, immed});

  // Next-state for output register and prefix latch.
  always_comb begin
    out_valid_d      = out_valid_q && !out_ready;
    ext_immed_d      = ext_immed_q;
    out_prefixed_d   = out_prefixed_q;
    prefix_pending_d = prefix_pending_q;
    prefix_d         = prefix_q;
    if (accept) begin
      if (mode == MODE_PREFIX) begin
        prefix_d         = immed;
        prefix_pending_d = 1'b1;
      end else begin
        out_valid_d      = 1'b1;
        prefix_pending_d = 1'b0;
        if (prefix_pending_q) begin
          ext_immed_d    = prefix_ext;
          out_prefixed_d = 1'b1;
        end else begin
          out_prefixed_d = 1'b0;
          case (mode)
            MODE_SIGN:   ext_immed_d = sign_ext;
            MODE_ZERO:   ext_immed_d = zero_ext;
            MODE_SHIFT1: ext_immed_d = shift_ext;
            default:     ext_immed_d = ext_immed_q;
          endcase
        end
      end
    end else begin
      ext_immed_d = ext_immed_q;
    end
  end

  // State registers; reset discards any pending prefix or stalled result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q      <= 1'b0;
      ext_immed_q      <= {DATA_W{1'b0}};
      out_prefixed_q   <= 1'b0;
      prefix_pending_q <= 1'b0;
      prefix_q         <= {IMM_W{1'b0}};
    end else begin
      out_valid_q      <= out_valid_d;
      ext_immed_q      <= ext_immed_d;
      out_prefixed_q   <= out_prefixed_d;
      prefix_pending_q <= prefix_pending_d;
      prefix_q         <= prefix_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign ext_immed      = ext_immed_q;
  assign out_prefixed   = out_prefixed_q;
  assign prefix_pending = prefix_pending_q;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Scoreboard bench for imm_extend_unit: directed requests push expected results,
// a negedge monitor pops and compares each consumed output.
module tb_imm_extend_unit;
  localparam int IMM_W  = 9;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  immed;
  logic [1:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ext_immed;
  logic              out_prefixed;
  logic              prefix_pending;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W:0] exp_q[$];

  imm_extend_unit #(.IMM_W(IMM_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .immed(immed), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .ext_immed(ext_immed), .out_prefixed(out_prefixed),
    .prefix_pending(prefix_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed when out_valid && out_ready at the edge.
  initial begin
    logic [DATA_W:0] e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected none", ext_immed);
        end else begin
          e = exp_q.pop_front();
          check("ext_immed", {16'h0000, ext_immed}, {16'h0000, e[DATA_W-1:0]});
          check("out_prefixed", {31'h0, out_prefixed}, {31'h0, e[DATA_W]});
        end
      end
    end
  end

  // Issue one request starting at posedge+1; returns at posedge+1 after acceptance.
  task automatic issue(input logic [1:0] m, input logic [IMM_W-1:0] v,
                       input logic push, input logic pfx, input logic [DATA_W-1:0] exp);
    bit done;
    done     = 1'b0;
    mode     = m;
    immed    = v;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    else if (push) exp_q.push_back({pfx, exp});
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mode      = 2'b00;
    immed     = 9'h000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_ext_immed", {16'h0, ext_immed}, 32'd0);
    check("rst_out_prefixed", {31'h0, out_prefixed}, 32'd0);
    check("rst_prefix_pending", {31'h0, prefix_pending}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'h0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Plain extension modes, back to back
    issue(2'b00, 9'h100, 1'b1, 1'b0, 16'hFF00);
    check("out_valid_latency1", {31'h0, out_valid}, 32'd1);
    issue(2'b00, 9'h0FF, 1'b1, 1'b0, 16'h00FF);
    issue(2'b01, 9'h1FF, 1'b1, 1'b0, 16'h01FF);
    issue(2'b10, 9'h1FF, 1'b1, 1'b0, 16'hFFFE);
    issue(2'b10, 9'h0C0, 1'b1, 1'b0, 16'h0180);

    // Prefix accepted during a consume leaves no output
    issue(2'b11, 9'h055, 1'b0, 1'b0, 16'h0000);
    check("prefix_no_output", {31'h0, out_valid}, 32'd0);
    check("prefix_pending_set", {31'h0, prefix_pending}, 32'd1);
    mode  = 2'b11;
    immed = 9'h1FF;
    repeat (2) @(posedge clk);
    #1;
    check("idle_keeps_prefix", {31'h0, prefix_pending}, 32'd1);
    check("idle_no_output", {31'h0, out_valid}, 32'd0);
    issue(2'b00, 9'h0AB, 1'b1, 1'b1, 16'hAAAB);
    check("prefix_pending_clear", {31'h0, prefix_pending}, 32'd0);
    issue(2'b00, 9'h0AB, 1'b1, 1'b0, 16'h00AB);

    // Back-to-back prefixes: last one wins
    issue(2'b11, 9'h001, 1'b0, 1'b0, 16'h0000);
    issue(2'b11, 9'h002, 1'b0, 1'b0, 16'h0000);
    check("prefix_overwrite_pending", {31'h0, prefix_pending}, 32'd1);
    issue(2'b01, 9'h000, 1'b1, 1'b1, 16'h0400);
    @(posedge clk); #1;

    // Backpressure: output held, no acceptance, then drain and load
    out_ready = 1'b0;
    issue(2'b00, 9'h001, 1'b1, 1'b0, 16'h0001);
    mode     = 2'b01;
    immed    = 9'h123;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'h0, in_ready}, 32'd0);
      check("stall_out_valid", {31'h0, out_valid}, 32'd1);
      check("stall_ext_immed", {16'h0, ext_immed}, 32'h0001);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_in_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 16'h0123});
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset discards a stalled result
    out_ready = 1'b0;
    issue(2'b00, 9'h002, 1'b0, 1'b0, 16'h0000);
    check("stalled_before_rst", {31'h0, out_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_drops_output", {31'h0, out_valid}, 32'd0);
    check("rst_drops_data", {16'h0, ext_immed}, 32'd0);

    // Reset discards a pending prefix
    issue(2'b11, 9'h07F, 1'b0, 1'b0, 16'h0000);
    check("prefix_before_rst", {31'h0, prefix_pending}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_drops_prefix", {31'h0, prefix_pending}, 32'd0);
    out_ready = 1'b1;
    issue(2'b00, 9'h001, 1'b1, 1'b0, 16'h0001);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
